// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass, optional hard-wired zero register and a busy scoreboard.
module regfile_sb #(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 16,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [DEPTH-1:0]  busy_vec
);

    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_we;
    logic              wr_to_zero;

    assign wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_we      = wr_en && !wr_to_zero;

    // Issue takes priority over writeback so a new producer replaces the old one.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
        if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign busy_d[gi] = 1'b0;
        end else begin : g_normal
            always_comb begin
                busy_d[gi] = busy_q[gi];
                if (iss_en && (iss_addr == ADDR_W'(gi))) begin
                    busy_d[gi] = 1'b1;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    busy_d[gi] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_we) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    logic [ADDR_W-1:0] rd_addr_a [2];
    logic [WIDTH-1:0]  rd_data_a [2];
    logic [1:0]        rd_busy_a;

    assign rd_addr_a[0] = rd_addr1;
    assign rd_addr_a[1] = rd_addr2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic addr_zero;
        logic wr_match;

        assign addr_zero = (ZERO_REG != 0) && (rd_addr_a[gi] == '0);
        assign wr_match  = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_a[gi]);

        always_comb begin
            rd_data_a[gi] = regs_q[rd_addr_a[gi]];
            if (addr_zero) begin
                rd_data_a[gi] = '0;
            end else if (wr_match) begin
                rd_data_a[gi] = wr_data;
            end
        end

        // A writeback landing this cycle already resolves the hazard.
        assign rd_busy_a[gi] = busy_q[rd_addr_a[gi]] & ~wr_match;
    end

    assign rd_data1 = rd_data_a[0];
    assign rd_data2 = rd_data_a[1];
    assign rd_busy1 = rd_busy_a[0];
    assign rd_busy2 = rd_busy_a[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks of regfile_sb: default build (bypass, zero reg) alongside a
// build with BYPASS=0 and ZERO_REG=0 driven by the same stimulus.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_addr1, rd_addr2, wr_addr, iss_addr;
    logic        wr_en, iss_en;
    logic [15:0] wr_data;

    logic [15:0] a_rd_data1, a_rd_data2, b_rd_data1, b_rd_data2;
    logic        a_rd_busy1, a_rd_busy2, b_rd_busy1, b_rd_busy2;
    logic [15:0] a_busy_vec, b_busy_vec;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    regfile_sb dut_a (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
        .rd_busy1(a_rd_busy1), .rd_busy2(a_rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_vec(a_busy_vec)
    );

    regfile_sb #(.BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
        .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_vec(b_busy_vec)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        rd_addr1 = 4'd0; rd_addr2 = 4'd0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0;
        iss_en = 1'b0; iss_addr = 4'd0;

        #3;
        check("reset_busy_vec_a", 32'(a_busy_vec), 32'h0);
        check("reset_busy_vec_b", 32'(b_busy_vec), 32'h0);
        check("reset_rd_data1_b", 32'(b_rd_data1), 32'h0);
        rst = 1'b1;

        // Preload reg 5 with data and busy in the same cycle.
        tick();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
        iss_en = 1'b1; iss_addr = 4'd5;
        rd_addr1 = 4'd5;
        tick(); idle(); #1;
        check("preload_data_a", 32'(a_rd_data1), 32'h1234);
        check("preload_busy_a", 32'(a_busy_vec), 32'h0020);

        // Asynchronous reset pulse between edges.
        #1 rst = 1'b0; #1;
        check("async_rst_data_a", 32'(a_rd_data1), 32'h0);
        check("async_rst_busy_a", 32'(a_busy_vec), 32'h0);
        check("async_rst_rdbusy_a", 32'(a_rd_busy1), 32'h0);
        rst = 1'b1;

        // Write/read with bypass.
        tick();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; rd_addr1 = 4'd3;
        #1;
        check("bypass_same_cycle_a", 32'(a_rd_data1), 32'hBEEF);
        check("nobypass_old_b", 32'(b_rd_data1), 32'h0000);
        tick(); idle(); #1;
        check("after_edge_a", 32'(a_rd_data1), 32'hBEEF);
        check("after_edge_b", 32'(b_rd_data1), 32'hBEEF);

        // Zero register: write and issue to address 0.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        iss_en = 1'b1; iss_addr = 4'd0; rd_addr2 = 4'd0;
        #1;
        check("zero_same_cycle_a", 32'(a_rd_data2), 32'h0);
        check("zero_same_cycle_b", 32'(b_rd_data2), 32'h0);
        tick(); idle(); #1;
        check("zero_data_a", 32'(a_rd_data2), 32'h0);
        check("zero_busy_a", 32'(a_busy_vec[0]), 32'h0);
        check("nozero_data_b", 32'(b_rd_data2), 32'hFFFF);
        check("nozero_busy_b", 32'(b_busy_vec[0]), 32'h1);

        // Scoreboard set on issue.
        iss_en = 1'b1; iss_addr = 4'd7; rd_addr1 = 4'd7;
        #1;
        check("issue_same_cycle_rdbusy_a", 32'(a_rd_busy1), 32'h0);
        tick(); idle(); #1;
        check("issue_busy_vec7_a", 32'(a_busy_vec[7]), 32'h1);
        check("issue_rdbusy_a", 32'(a_rd_busy1), 32'h1);

        // Writeback clears; bypass hides the hazard in the same cycle.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0777;
        #1;
        check("wb_rdbusy_bypass_a", 32'(a_rd_busy1), 32'h0);
        check("wb_rdbusy_nobypass_b", 32'(b_rd_busy1), 32'h1);
        check("wb_busy_vec_still_a", 32'(a_busy_vec), 32'h0080);
        tick(); idle(); #1;
        check("wb_cleared_a", 32'(a_busy_vec), 32'h0000);
        check("wb_cleared_b", 32'(b_busy_vec), 32'h0001);

        // Collision: issue and writeback to reg 9.
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h00AA;
        iss_en = 1'b1; iss_addr = 4'd9;
        tick(); idle(); rd_addr1 = 4'd9; rd_addr2 = 4'd9; #1;
        check("collision_data_a", 32'(a_rd_data1), 32'h00AA);
        check("collision_busy_a", 32'(a_busy_vec), 32'h0200);
        check("collision_busy_b", 32'(b_busy_vec), 32'h0201);

        // Issue to an already-busy register keeps it busy.
        iss_en = 1'b1; iss_addr = 4'd9;
        tick(); idle(); #1;
        check("waw_busy_a", 32'(a_busy_vec), 32'h0200);

        // Both ports bypass independently.
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h1111;
        #1;
        check("dual_bypass1_a", 32'(a_rd_data1), 32'h1111);
        check("dual_bypass2_a", 32'(a_rd_data2), 32'h1111);
        check("dual_old2_b", 32'(b_rd_data2), 32'h00AA);
        check("dual_rdbusy2_a", 32'(a_rd_busy2), 32'h0);
        check("dual_rdbusy2_b", 32'(b_rd_busy2), 32'h1);
        tick(); idle(); #1;
        check("dual_cleared_a", 32'(a_busy_vec), 32'h0000);

        // Writes and issues are ignored while reset is held.
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h5555;
        iss_en = 1'b1; iss_addr = 4'd4; rd_addr1 = 4'd4;
        #1;
        check("rst_bypass_a", 32'(a_rd_data1), 32'h5555);
        check("rst_rdbusy_a", 32'(a_rd_busy1), 32'h0);
        tick(); #1;
        check("rst_busy_held_a", 32'(a_busy_vec), 32'h0);
        idle(); rst = 1'b1; #1;
        check("rst_write_ignored_a", 32'(a_rd_data1), 32'h0);
        check("rst_write_ignored_b", 32'(b_rd_data1), 32'h0);
        check("rst_reg9_cleared_b", 32'(b_rd_data2), 32'h0);

        // First edge after reset release behaves normally.
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444;
        tick(); idle(); #1;
        check("post_rst_write_b", 32'(b_rd_data1), 32'h4444);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
